// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types and encodings for the multi-cycle RV32I control
//                unit: FSM states, opcodes, datapath select codes, trap causes.
//  Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWR  = 4'd4,
        MEMWB  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that hold a memory request open and may stall on mem_ready
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit_if
//  Description : Control/status bundle between the controller (master) and
//                the datapath + memory side (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 7
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                adr_src;
    logic                ir_write;
    logic                pc_write;
    logic                reg_write;
    logic [1:0]          result_src;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic                trap;
    logic [1:0]          trap_cause;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, trap, trap_cause
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, trap, trap_cause
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_timer
//  Description : Saturating count of consecutive not-ready memory cycles;
//                flags a timeout when the limit is reached and still stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic count_en,
    output logic      timeout
);
    localparam int                c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_count;

    // Count stalled cycles; a state change restarts the count, the limit holds it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // count_en already excludes mem_ready, so a ready beat always beats the timeout
    assign timeout = (TIMEOUT_CYCLES > 0) && count_en && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Moore FSM main controller for a multi-cycle RV32I core.
//                Sequences fetch/decode/execute/memory/writeback, stalls on
//                mem_ready with a bounded wait, traps on illegal opcodes.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W       = 7,
    parameter int ENABLE_ITYPE   = 1,
    parameter int ENABLE_JAL     = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    multicycle_control_unit_if.master  bus
);
    state_t              r_state;
    state_t              w_next;
    logic                r_trap;
    logic [1:0]          r_cause;
    logic [1:0]          w_cause_next;
    logic                w_timeout;
    logic [OPCODE_W-1:0] w_opc_full;
    logic [6:0]          w_opc;

    logic       w_mem_req, w_mem_we, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op;

    assign w_opc_full = bus.opcode;
    assign w_opc      = w_opc_full[6:0];

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (r_state != w_next),
        .count_en (is_mem_state(r_state) && !bus.mem_ready),
        .timeout  (w_timeout)
    );

    // State register; trap flag and cause are captured once, on entry to TRAP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_trap  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            if ((w_next == TRAP) && (r_state != TRAP)) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause_next;
            end
        end
    end

    // Next-state selection from current state, opcode and memory handshake
    always_comb begin
        w_next       = r_state;
        w_cause_next = CAUSE_NONE;
        case (r_state)
            FETCH, MEMRD, MEMWR: begin
                if (bus.mem_ready) begin
                    w_next = (r_state == FETCH) ? DECODE :
                             (r_state == MEMRD) ? MEMWB  : FETCH;
                end else if (w_timeout) begin
                    w_next       = TRAP;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                w_next       = TRAP;
                w_cause_next = CAUSE_ILLEGAL;
                case (w_opc)
                    OPC_LOAD, OPC_STORE: w_next = MEMADR;
                    OPC_RTYPE:           w_next = EXEC_R;
                    OPC_BRANCH:          w_next = BRANCH;
                    OPC_ITYPE:           if (ENABLE_ITYPE != 0) w_next = EXEC_I;
                    OPC_JAL:             if (ENABLE_JAL != 0)   w_next = JAL;
                    default:             w_next = TRAP;
                endcase
                if (w_next != TRAP) w_cause_next = CAUSE_NONE;
            end
            MEMADR:                 w_next = (w_opc == OPC_LOAD) ? MEMRD : MEMWR;
            MEMWB, ALUWB, BRANCH:   w_next = FETCH;
            EXEC_R, EXEC_I, JAL:    w_next = ALUWB;
            TRAP:                   w_next = TRAP;
            default:                w_next = FETCH;
        endcase
    end

    // Datapath controls decoded from state; a timeout cycle issues no strobes
    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            FETCH: begin
                w_mem_req   = !w_timeout;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
                w_alu_src_b = SRCB_FOUR;
            end
            DECODE: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                w_mem_req = !w_timeout;
                w_adr_src = 1'b1;
            end
            MEMWR: begin
                w_mem_req = !w_timeout;
                w_mem_we  = !w_timeout;
                w_adr_src = 1'b1;
            end
            MEMWB: begin
                w_reg_write  = 1'b1;
                w_result_src = RES_MEMDATA;
            end
            EXEC_R: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_op    = ALUOP_RTYPE;
            end
            EXEC_I: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
                w_alu_op    = ALUOP_ITYPE;
            end
            ALUWB:  w_reg_write = 1'b1;
            BRANCH: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_op    = ALUOP_SUB;
                w_pc_write  = bus.zero;
            end
            JAL: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_FOUR;
                w_pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces every output low in the same cycle, abandoning any access
    assign bus.mem_req    = !rst && w_mem_req;
    assign bus.mem_we     = !rst && w_mem_we;
    assign bus.adr_src    = !rst && w_adr_src;
    assign bus.ir_write   = !rst && w_ir_write;
    assign bus.pc_write   = !rst && w_pc_write;
    assign bus.reg_write  = !rst && w_reg_write;
    assign bus.result_src = rst ? 2'b00 : w_result_src;
    assign bus.alu_src_a  = rst ? 2'b00 : w_alu_src_a;
    assign bus.alu_src_b  = rst ? 2'b00 : w_alu_src_b;
    assign bus.alu_op     = rst ? 2'b00 : w_alu_op;
    assign bus.trap       = !rst && r_trap;
    assign bus.trap_cause = rst ? 2'b00 : r_cause;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Cycle-by-cycle vector table for two controller instances
//                (A: JAL disabled, 3-cycle timeout; B: defaults).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control_unit;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] r_opc = 7'd0;
    logic       r_zero = 1'b0;
    logic       r_rdy = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_unit_if bus_a ();
    multicycle_control_unit_if bus_b ();

    assign bus_a.opcode = r_opc;  assign bus_a.zero = r_zero;  assign bus_a.mem_ready = r_rdy;
    assign bus_b.opcode = r_opc;  assign bus_b.zero = r_zero;  assign bus_b.mem_ready = r_rdy;

    multicycle_control_unit #(.OPCODE_W(7), .ENABLE_ITYPE(1), .ENABLE_JAL(0), .TIMEOUT_CYCLES(3))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    multicycle_control_unit #(.OPCODE_W(7), .ENABLE_ITYPE(1), .ENABLE_JAL(1), .TIMEOUT_CYCLES(15))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, result_src, a, b, alu_op, trap, trap_cause}
    logic [16:0] out_a, out_b;
    assign out_a = {bus_a.mem_req, bus_a.mem_we, bus_a.adr_src, bus_a.ir_write, bus_a.pc_write,
                    bus_a.reg_write, bus_a.result_src, bus_a.alu_src_a, bus_a.alu_src_b,
                    bus_a.alu_op, bus_a.trap, bus_a.trap_cause};
    assign out_b = {bus_b.mem_req, bus_b.mem_we, bus_b.adr_src, bus_b.ir_write, bus_b.pc_write,
                    bus_b.reg_write, bus_b.result_src, bus_b.alu_src_a, bus_b.alu_src_b,
                    bus_b.alu_op, bus_b.trap, bus_b.trap_cause};

    typedef struct {
        bit          b;
        logic        r;
        logic [6:0]  opc;
        logic        z;
        logic        rdy;
        logic [16:0] exp;
        string       nm;
    } vec_t;

    typedef struct {
        logic [16:0] exp;
        bit          b;
        string       nm;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [16:0] o(input logic mreq, we, adr, irw, pcw, rw,
                                      input logic [1:0] res, a, b, op,
                                      input logic tr, input logic [1:0] cs);
        return {mreq, we, adr, irw, pcw, rw, res, a, b, op, tr, cs};
    endfunction

    task automatic add(input bit b, input logic r, input logic [6:0] opc, input logic z,
                       input logic rdy, input logic [16:0] exp, input string nm);
        vec_t v;
        v.b = b; v.r = r; v.opc = opc; v.z = z; v.rdy = rdy; v.exp = exp; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic check(input logic [16:0] got, input logic [16:0] exp,
                         input string nm, input int row);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (row %0d): got %b want %b", nm, row, got, exp);
        end
    endtask

    logic [16:0] RST, F_NR, F_RDY, F_TO, DEC, MADR, MRD, MWR, MWR_TO, MWB;
    logic [16:0] EXR, EXI, AWB, BR1, BR0, JALO, TR_ILL, TR_TO;

    initial begin
        sb_t         e;
        logic [16:0] got;

        RST    = '0;
        F_NR   = o(1,0,0,0,0,0, 2'd0,2'd0,2'd2,2'd0, 0,2'd0);
        F_RDY  = o(1,0,0,1,1,0, 2'd0,2'd0,2'd2,2'd0, 0,2'd0);
        F_TO   = o(0,0,0,0,0,0, 2'd0,2'd0,2'd2,2'd0, 0,2'd0);
        DEC    = o(0,0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0, 0,2'd0);
        MADR   = o(0,0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0, 0,2'd0);
        MRD    = o(1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0);
        MWR    = o(1,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0);
        MWR_TO = o(0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0);
        MWB    = o(0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0, 0,2'd0);
        EXR    = o(0,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2, 0,2'd0);
        EXI    = o(0,0,0,0,0,0, 2'd0,2'd2,2'd1,2'd3, 0,2'd0);
        AWB    = o(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 0,2'd0);
        BR1    = o(0,0,0,0,1,0, 2'd0,2'd2,2'd0,2'd1, 0,2'd0);
        BR0    = o(0,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd1, 0,2'd0);
        JALO   = o(0,0,0,0,1,0, 2'd0,2'd1,2'd2,2'd0, 0,2'd0);
        TR_ILL = o(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,2'd1);
        TR_TO  = o(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,2'd2);

        // Reset with ready high: nothing may be requested
        add(0,1,OPC_RTYPE,0,1,RST,"reset0");
        add(0,1,OPC_RTYPE,0,1,RST,"reset1");
        // R-type, zero-wait fetch: 4 cycles
        add(0,0,OPC_RTYPE,0,1,F_RDY,"r_fetch");
        add(0,0,OPC_RTYPE,0,0,DEC,"r_decode");
        add(0,0,OPC_RTYPE,0,1,EXR,"r_exec");
        add(0,0,OPC_RTYPE,0,1,AWB,"r_aluwb");
        // Load, 3 stalled read cycles: 8 cycles
        add(0,0,OPC_LOAD,0,1,F_RDY,"ld_fetch");
        add(0,0,OPC_LOAD,0,0,DEC,"ld_decode");
        add(0,0,OPC_LOAD,0,1,MADR,"ld_memadr");
        for (int k = 0; k < 3; k++) add(0,0,OPC_LOAD,0,0,MRD,"ld_memrd_wait");
        add(0,0,OPC_LOAD,0,1,MRD,"ld_memrd_done");
        add(0,0,OPC_LOAD,0,1,MWB,"ld_memwb");
        // BEQ taken then not taken
        add(0,0,OPC_BRANCH,0,1,F_RDY,"beq1_fetch");
        add(0,0,OPC_BRANCH,0,0,DEC,"beq1_decode");
        add(0,0,OPC_BRANCH,1,0,BR1,"beq_taken");
        add(0,0,OPC_BRANCH,0,1,F_RDY,"beq0_fetch");
        add(0,0,OPC_BRANCH,0,0,DEC,"beq0_decode");
        add(0,0,OPC_BRANCH,0,0,BR0,"beq_not_taken");
        // I-type
        add(0,0,OPC_ITYPE,0,1,F_RDY,"i_fetch");
        add(0,0,OPC_ITYPE,0,0,DEC,"i_decode");
        add(0,0,OPC_ITYPE,0,0,EXI,"i_exec");
        add(0,0,OPC_ITYPE,0,0,AWB,"i_aluwb");
        // Store ready exactly on the 4th write cycle: completes, no trap
        add(0,0,OPC_STORE,0,1,F_RDY,"st_fetch");
        add(0,0,OPC_STORE,0,0,DEC,"st_decode");
        add(0,0,OPC_STORE,0,1,MADR,"st_memadr");
        for (int k = 0; k < 3; k++) add(0,0,OPC_STORE,0,0,MWR,"st_memwr_wait");
        add(0,0,OPC_STORE,0,1,MWR,"st_memwr_late_ready");
        add(0,0,OPC_STORE,0,0,F_NR,"st_back_to_fetch");
        // Fetch completes, then store never ready: timeout on the 4th write cycle
        add(0,0,OPC_STORE,0,1,F_RDY,"sto_fetch");
        add(0,0,OPC_STORE,0,0,DEC,"sto_decode");
        add(0,0,OPC_STORE,0,0,MADR,"sto_memadr");
        for (int k = 0; k < 3; k++) add(0,0,OPC_STORE,0,0,MWR,"sto_memwr_wait");
        add(0,0,OPC_STORE,0,0,MWR_TO,"sto_timeout_cycle");
        for (int k = 0; k < 4; k++) add(0,0,OPC_RTYPE,1,1,TR_TO,"sto_trap_held");
        add(0,1,OPC_RTYPE,0,0,RST,"sto_reset");
        add(0,0,OPC_RTYPE,0,0,F_NR,"sto_trap_cleared");
        // Fetch timeout (continues from the fetch above: one stall already counted)
        for (int k = 0; k < 2; k++) add(0,0,OPC_RTYPE,0,0,F_NR,"fto_wait");
        add(0,0,OPC_RTYPE,0,0,F_TO,"fto_timeout_cycle");
        add(0,0,OPC_RTYPE,0,1,TR_TO,"fto_trap");
        add(0,1,OPC_RTYPE,0,0,RST,"fto_reset");
        // Illegal opcode: trap held 20 cycles, cause never overwritten
        add(0,0,7'b0001111,0,1,F_RDY,"ill_fetch");
        add(0,0,7'b0001111,0,0,DEC,"ill_decode");
        for (int k = 0; k < 20; k++)
            add(0,0,(k % 2 == 0) ? OPC_LOAD : OPC_STORE,k[0],(k % 3 == 0),TR_ILL,"ill_trap_held");
        add(0,1,OPC_RTYPE,0,0,RST,"ill_reset");
        add(0,0,OPC_RTYPE,0,0,F_NR,"ill_trap_cleared");
        // JAL on the JAL-disabled instance is illegal
        add(0,0,OPC_JAL,0,1,F_RDY,"jaloff_fetch");
        add(0,0,OPC_JAL,0,0,DEC,"jaloff_decode");
        for (int k = 0; k < 3; k++) add(0,0,OPC_JAL,0,0,TR_ILL,"jaloff_trap");
        add(0,1,OPC_RTYPE,0,0,RST,"jaloff_reset");
        // Reset during a stalled read; counter must restart from zero afterwards
        add(0,0,OPC_LOAD,0,1,F_RDY,"rr_fetch");
        add(0,0,OPC_LOAD,0,0,DEC,"rr_decode");
        add(0,0,OPC_LOAD,0,0,MADR,"rr_memadr");
        for (int k = 0; k < 2; k++) add(0,0,OPC_LOAD,0,0,MRD,"rr_memrd_wait");
        add(0,1,OPC_LOAD,0,0,RST,"rr_reset_drops_req");
        for (int k = 0; k < 3; k++) add(0,0,OPC_LOAD,0,0,F_NR,"rr_fetch_wait");
        add(0,0,OPC_LOAD,0,1,F_RDY,"rr_fetch_done");
        add(0,1,OPC_RTYPE,0,0,RST,"rr_reset_end");
        // Default instance: JAL enabled, long timeout
        add(1,1,OPC_JAL,0,0,RST,"b_reset");
        for (int k = 0; k < 6; k++) add(1,0,OPC_JAL,0,0,F_NR,"b_fetch_wait");
        add(1,0,OPC_JAL,0,1,F_RDY,"b_jal_fetch");
        add(1,0,OPC_JAL,0,0,DEC,"b_jal_decode");
        add(1,0,OPC_JAL,0,0,JALO,"b_jal");
        add(1,0,OPC_JAL,0,0,AWB,"b_jal_aluwb");
        add(1,0,OPC_JAL,0,0,F_NR,"b_back_to_fetch");

        foreach (tbl[i]) begin
            @(negedge clk);
            rst    = tbl[i].r;
            r_opc  = tbl[i].opc;
            r_zero = tbl[i].z;
            r_rdy  = tbl[i].rdy;
            sb.push_back('{exp: tbl[i].exp, b: tbl[i].b, nm: tbl[i].nm});
            #2;
            e   = sb.pop_front();
            got = e.b ? out_b : out_a;
            check(got, e.exp, e.nm, i);
            if (tbl[i].r) begin
                check(out_a | out_b, 17'd0, "reset_state_all_zero", i);
            end
            if ((e.nm == "sto_trap_held") || (e.nm == "fto_trap")) begin
                check({14'd0, out_a[2:0]}, {14'd0, 1'b1, CAUSE_TIMEOUT}, "expired_wait_trap", i);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
